// File: rtl/read_data.sv
// Sample-capture / peak-hold front end for the hex display.
// Groups accepted samples into WINDOW-sized windows and latches {window count, window peak}.
module read_data #(
    parameter int WINDOW = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] data,
    input  logic        data_rdy,
    output logic [31:0] disp_val
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    logic [CW-1:0] r_sample_cnt;
    logic [17:0]   r_peak_run;
    logic [13:0]   r_win_cnt;
    logic [31:0]   r_disp_val;

    logic [17:0]   w_cand;
    logic [13:0]   w_win_next;

    // First sample of a window seeds the peak; ties keep the held value.
    assign w_cand     = (r_sample_cnt == '0 || data > r_peak_run) ? data : r_peak_run;
    assign w_win_next = r_win_cnt + 14'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sample_cnt <= '0;
            r_peak_run   <= '0;
            r_win_cnt    <= '0;
            r_disp_val   <= '0;
        end else if (data_rdy) begin
            if (r_sample_cnt == LAST) begin
                r_win_cnt    <= w_win_next;
                r_disp_val   <= {w_win_next, w_cand};
                r_sample_cnt <= '0;
            end else begin
                r_peak_run   <= w_cand;
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    assign disp_val = r_disp_val;

endmodule

// File: tb/tb_read_data.sv
// Bench for read_data: three instances (WINDOW = 4, 1, 1024) checked against a
// queue-based window model every cycle, plus hand-computed display words.
module tb_read_data;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] d4 = '0, d1 = '0, dk = '0;
    logic        r4 = 1'b0, r1 = 1'b0, rk = 1'b0;
    logic [31:0] disp4, disp1, dispk;

    int npass = 0;
    int ncheck = 0;

    always #5 clock = ~clock;

    read_data #(.WINDOW(4))  u4  (.clock(clock), .reset(reset), .data(d4), .data_rdy(r4), .disp_val(disp4));
    read_data #(.WINDOW(1))  u1  (.clock(clock), .reset(reset), .data(d1), .data_rdy(r1), .disp_val(disp1));
    read_data                uk  (.clock(clock), .reset(reset), .data(dk), .data_rdy(rk), .disp_val(dispk));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Model: collect the window's samples, and when the window is full
    // publish {completed-window count mod 2^14, largest sample}.
    function automatic logic [31:0] pack(input int cnt, input int unsigned pk);
        logic [13:0] c;
        logic [17:0] p;
        c = cnt[13:0];
        p = pk[17:0];
        return {c, p};
    endfunction

    int unsigned q4[$], q1[$], qk[$];
    int          c4 = 0, c1 = 0, ck = 0;
    logic [31:0] m4 = '0, m1 = '0, mk = '0;

    function automatic int unsigned qmax(input int unsigned q[$]);
        int unsigned m = 0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            q4.delete(); q1.delete(); qk.delete();
            c4 = 0; c1 = 0; ck = 0;
            m4 = '0; m1 = '0; mk = '0;
        end else begin
            if (r4) begin
                q4.push_back(d4);
                if (q4.size() == 4) begin c4 = (c4 + 1) % 16384; m4 = pack(c4, qmax(q4)); q4.delete(); end
            end
            if (r1) begin
                q1.push_back(d1);
                if (q1.size() == 1) begin c1 = (c1 + 1) % 16384; m1 = pack(c1, qmax(q1)); q1.delete(); end
            end
            if (rk) begin
                qk.push_back(dk);
                if (qk.size() == 1024) begin ck = (ck + 1) % 16384; mk = pack(ck, qmax(qk)); qk.delete(); end
            end
        end
    end

    always @(negedge clock) begin
        chk("model_w4", disp4, m4);
        chk("model_w1", disp1, m1);
        chk("model_w1024", dispk, mk);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [17:0] s4 [4];

    initial begin
        s4[0] = 18'h00005; s4[1] = 18'h3FFFF; s4[2] = 18'h00010; s4[3] = 18'h00002;

        // Reset held with strobes toggling: nothing may be accepted.
        for (int i = 0; i < 10; i++) begin
            r4 = i[0]; r1 = i[0]; rk = i[0];
            d4 = 18'h3FFFF; d1 = 18'h12345; dk = 18'h00777;
            tick();
            chk("reset_w4", disp4, 32'h0);
            chk("reset_w1", disp1, 32'h0);
        end
        reset = 1'b0; r4 = 0; r1 = 0; rk = 0;
        tick();
        chk("post_reset_w4", disp4, 32'h0);
        chk("post_reset_w1k", dispk, 32'h0);

        // WINDOW=4, sparse strobes.
        for (int k = 0; k < 4; k++) begin
            if (k == 3) chk("w4_hold_before_last", disp4, 32'h0);
            d4 = s4[k]; r4 = 1'b1;
            tick();
            r4 = 1'b0;
            if (k < 3) chk("w4_hold", disp4, 32'h0);
            repeat (15) tick();
        end
        chk("w4_first_window", disp4, 32'h0007FFFF);

        // Back-to-back 1,2,3,4: earlier peak must not carry over.
        for (int k = 1; k <= 4; k++) begin
            d4 = 18'(k); r4 = 1'b1;
            tick();
            if (k < 4) chk("w4_second_hold", disp4, 32'h0007FFFF);
        end
        r4 = 1'b0;
        chk("w4_second_window", disp4, 32'h00080004);

        // Partial window, then reset (with a large strobed sample) discards it.
        for (int k = 0; k < 2; k++) begin d4 = 18'h3FFF0; r4 = 1'b1; tick(); end
        reset = 1'b1; d4 = 18'h3FFFF;
        tick();
        reset = 1'b0; r4 = 1'b0;
        chk("w4_reset_clears", disp4, 32'h0);
        for (int k = 0; k < 4; k++) begin d4 = 18'h00001; r4 = 1'b1; tick(); end
        r4 = 1'b0;
        chk("w4_after_reset", disp4, 32'h00040001);

        fork
            begin
                for (int i = 0; i < 65540; i++) begin
                    d1 = 18'(i); r1 = 1'b1;
                    tick();
                    if (i == 0)     chk("w1_first", disp1, 32'h00040000);
                    if (i == 16382) chk("w1_pre_wrap", disp1, 32'hFFFC3FFE);
                    if (i == 16383) chk("w1_wrap", disp1, 32'h00003FFF);
                end
                r1 = 1'b0;
                chk("w1_final", disp1, 32'h00110003);
            end
            begin
                for (int c = 0; c < 32768; c++) begin
                    dk = 18'(c); rk = (c % 16 == 15);
                    tick();
                    if (c == 16382) chk("w1k_before_update", dispk, 32'h0);
                    if (c == 16383) chk("w1k_update1", dispk, 32'h00043FFF);
                    if (c == 32766) chk("w1k_hold", dispk, 32'h00043FFF);
                end
                rk = 1'b0;
                chk("w1k_update2", dispk, 32'h00087FFF);
            end
        join

        repeat (2) tick();
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
